// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU pipeline control slice: controller state
// encoding and default geometry parameters.
package cpu_ctrl_pkg;

   localparam int REG_W       = 5;
   localparam int MEM_TIMEOUT = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DMEM_WAIT,
      ST_HALT,
      ST_ERR
   } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: an EX-stage load whose destination is
// read by the instruction currently in ID.
module hazard_detect #(
   parameter int REG_W = cpu_ctrl_pkg::REG_W
) (
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   output logic             load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = id_use_rs && (id_rs == ex_rd);
   assign rt_hit = id_use_rt && (id_rt == ex_rd);

   // Register 0 is hard-wired, so a load targeting it never creates a dependency.
   assign load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: Mealy control of the
// PC and pipeline registers, dmem wait/timeout, debug halt and stall accounting.
module pipe_hazard_ctrl #(
   parameter int REG_W       = cpu_ctrl_pkg::REG_W,
   parameter int MEM_TIMEOUT = cpu_ctrl_pkg::MEM_TIMEOUT,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic             ex_branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_ce,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_stall,
   output logic             idex_flush,
   output logic             exmem_stall,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] stall_cycles
);

   import cpu_ctrl_pkg::*;

   localparam int                WCNT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

   ctrl_state_e       state_reg, state_next;
   logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
   logic [CNT_W-1:0]  stall_cnt_reg;
   logic              load_use;
   logic              dmem_miss;
   logic              freeze;

   hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .ex_rd        (ex_rd),
      .ex_mem_read  (ex_mem_read),
      .ex_reg_write (ex_reg_write),
      .load_use     (load_use)
   );

   assign dmem_miss    = dmem_req && !dmem_ready;
   assign stall_cycles = stall_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         wcnt_reg      <= '0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
         if (pc_stall && (state_reg != ST_IDLE) && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   // pc_stall defaults high and pc_ce low: only the advancing RUN cases release the PC.
   always_comb begin
      state_next  = state_reg;
      wcnt_next   = wcnt_reg;
      freeze      = 1'b0;
      pc_ce       = 1'b0;
      pc_stall    = 1'b1;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      exmem_stall = 1'b0;
      halted      = 1'b0;
      err         = 1'b0;

      unique case (state_reg)
         ST_IDLE: begin
            if (en) begin
               state_next = ST_RUN;
               wcnt_next  = '0;
            end
         end
         ST_RUN: begin
            if (dmem_miss) begin
               freeze     = 1'b1;
               state_next = ST_DMEM_WAIT;
               wcnt_next  = WCNT_W'(1);
            end else if (!en) begin
               freeze     = 1'b1;
               state_next = ST_HALT;
            end else if (ex_branch_taken) begin
               pc_ce      = 1'b1;
               pc_stall   = 1'b0;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (load_use) begin
               ifid_stall = 1'b1;
               idex_flush = 1'b1;
            end else if (!imem_ready) begin
               ifid_flush = 1'b1;
            end else begin
               pc_ce    = 1'b1;
               pc_stall = 1'b0;
            end
         end
         ST_DMEM_WAIT: begin
            freeze = 1'b1;
            if (dmem_ready) begin
               state_next = ST_RUN;
               wcnt_next  = '0;
            end else if (wcnt_reg == WCNT_MAX) begin
               state_next = ST_ERR;
            end else begin
               wcnt_next = wcnt_reg + WCNT_W'(1);
            end
         end
         ST_HALT: begin
            freeze = 1'b1;
            halted = 1'b1;
            if (en) begin
               state_next = ST_RUN;
               wcnt_next  = '0;
            end
         end
         ST_ERR: begin
            freeze = 1'b1;
            err    = 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase

      if (freeze) begin
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipelined CPU. It sequences the PC register, the IF/ID, ID/EX and EX/MEM pipeline registers by driving their load-enable, stall and flush controls. It resolves:

- load-use hazards
- taken-branch flushes
- instruction-memory wait states
- data-memory wait states, with timeout
- debug halt

It sits beside the datapath and takes decoded register fields from ID and EX.

## Interface
Parameters:
- REG_W, 5, register-index width
- MEM_TIMEOUT, 15, max consecutive dmem wait cycles before error
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run enable; 0 requests halt
- id_rs, id_rt  in  REG_W  source registers of ID instruction
- id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt
- ex_rd  in  REG_W  destination of EX instruction
- ex_mem_read, ex_reg_write  in  1  EX instruction is a load / writes a register
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- imem_ready  in  1  fetch data valid this cycle
- dmem_req, dmem_ready  in  1  MEM stage access pending / completes this cycle
- pc_ce, pc_stall  out  1  PC load-enable / hold
- ifid_stall, ifid_flush  out  1  IF/ID hold / clear to bubble
- idex_stall, idex_flush  out  1  ID/EX hold / clear to bubble
- exmem_stall  out  1  EX/MEM hold
- halted, err  out  1  in HALT state / in ERR state (sticky)
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1 outside IDLE

## Operation
FSM states: IDLE, RUN, DMEM_WAIT, HALT, ERR. Control outputs are Mealy, combinational from the state and current inputs. A "freeze" asserts pc_stall, ifid_stall, idex_stall and exmem_stall, with pc_ce=0 and no flushes.

- IDLE (reset state): pc_ce=0, pc_stall=1, all else 0. Goes to RUN when en=1.
- RUN: evaluate the following in priority order; the first match wins.
  1. dmem_req && !dmem_ready: freeze; next state DMEM_WAIT; wait counter = 1.
  2. en=0: freeze; next state HALT.
  3. ex_branch_taken: pc_ce=1, pc_stall=0, ifid_flush=1, idex_flush=1. This overrides the load-use and imem conditions.
  4. Load-use: ex_mem_read && ex_reg_write && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)). Response: pc_stall=1, pc_ce=0, ifid_stall=1, idex_flush=1. This gives a one-cycle bubble.
  5. !imem_ready: pc_stall=1, pc_ce=0, ifid_flush=1; later stages advance.
  6. Otherwise: pc_ce=1, all stalls and flushes 0.
- DMEM_WAIT: freeze.
  - dmem_ready=1: next state RUN; outputs are still freeze this cycle.
  - Else, wait counter == MEM_TIMEOUT: next state ERR.
  - Else: counter increments.
- HALT: freeze; halted=1. Goes to RUN when en=1. dmem_req is ignored, because a pending access was completed before entry.
- ERR: freeze; err=1. Only rst exits.
- stall_cycles increments on every clk edge where pc_stall=1 and the state is not IDLE. It saturates at all-ones.
- Wait counter is an internal register of width clog2(MEM_TIMEOUT+1). It is cleared on entry to RUN.

## Timing
- While rst=1: state IDLE, all counters 0. Outputs: pc_stall=1, all other outputs 0, halted=0, err=0.
- Reset mid-operation: the same values apply asynchronously, and any DMEM_WAIT or ERR state is abandoned.
- Zero-latency control: outputs respond in the same cycle as the inputs. State changes take effect at the next posedge clk.
- Load-use bubble lasts exactly 1 cycle. In the next cycle the load is in MEM, the hazard term is false, and the pipeline resumes.
- A taken branch costs 2 flushed slots. The PC target is loaded on the same edge as the flush.
- DMEM wait of N cycles (dmem_ready in the Nth cycle, N ≤ MEM_TIMEOUT) gives N frozen cycles, then RUN.
- Timeout: with no dmem_ready, ERR is entered at the edge ending wait cycle MEM_TIMEOUT+1.
- Simultaneous events:
  - dmem wait beats en=0, branch and load-use.
  - Branch beats load-use and imem wait.
  - en=0 together with a branch means halt; the branch is re-presented after resume because the pipeline is frozen.

## Structure
- Shared package `cpu_ctrl_pkg`: state enum, REG_W, and the default MEM_TIMEOUT.
- One sub-module, `hazard_detect`: the purely combinational load-use comparator (term 4), reusable by the forwarding unit.
- The FSM, counters and output priority logic live in pipe_hazard_ctrl.

## Test plan
- Reset and start: hold rst 3 cycles, then en=1. During rst: pc_stall=1, pc_ce=0, stall_cycles=0. The cycle after: RUN, pc_ce=1.
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs=5, id_use_rs=1. Required: pc_stall=ifid_stall=idex_flush=1 for one cycle; stall_cycles 0→1. Repeat with ex_rd=0: no stall.
- Branch during hazard: load-use condition plus ex_branch_taken=1. Required: pc_ce=1, ifid_flush=idex_flush=1, pc_stall=0.
- DMEM wait: dmem_req=1 with dmem_ready low for 4 cycles, then high. Required: 5 frozen cycles, then RUN; err=0.
- Timeout: dmem_req=1, dmem_ready=0 for 20 cycles. Required: err=1 after wait cycle 16 (MEM_TIMEOUT=15), and the pipeline stays frozen. Then rst: err=0, state IDLE.
- Halt plus imem: en=0 for 3 cycles gives halted=1 and a freeze; en=1 resumes. Then imem_ready=0 for 2 cycles gives pc_stall=1, ifid_flush=1, idex_stall=0.
